ddr_rd_unpack_256to16: RTL and testbench

//  Read-back width converter: 256-bit words from the DDR read path are split into 16-bit pixels for the video output.
//  2-entry prefetch buffer decouples burst arrival from the pixel-rate consumer.

---
 rtl/ddr_rd_unpack_256to16_pkg.sv | 16 +
 rtl/ddr_rd_unpack_256to16_unpack_lane_mux.sv | 36 +++
 rtl/ddr_rd_unpack_256to16.sv | 120 ++++++++++++
 tb/tb_ddr_rd_unpack_256to16.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_rd_unpack_256to16_pkg.sv
// Shared definitions for the DDR read-side unpacker and the matching write-side packer.
// Word/pixel widths, occupancy encoding and the lane-index width.
package ddr_rd_unpack_256to16_pkg;

  localparam int unsigned DEF_IN_W  = 256;
  localparam int unsigned DEF_OUT_W = 16;
  localparam int unsigned DEF_LANES = DEF_IN_W / DEF_OUT_W;
  localparam int unsigned LW        = $clog2(DEF_LANES);

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

endpackage

// File: rtl/ddr_rd_unpack_256to16_unpack_lane_mux.sv
// Selects one OUT_W pixel from the head word by lane index.
// Lane order is LSB-first unless UNPACK_MSB_FIRST_EN is defined (then MSB-first).
module unpack_lane_mux
  import ddr_rd_unpack_256to16_pkg::*;
#(
  parameter int unsigned IN_W   = DEF_IN_W,
  parameter int unsigned OUT_W  = DEF_OUT_W,
  parameter int unsigned LANES  = IN_W / OUT_W,
  parameter int unsigned LANE_W = LW
) (
  input  logic [IN_W-1:0]   word,
  input  logic [LANE_W-1:0] lane,
  output logic [OUT_W-1:0]  pix_c
);

  logic [LANE_W-1:0] idx_c;

  // Physical lane index after applying the configured lane order
  always_comb begin
`ifdef UNPACK_MSB_FIRST_EN
    idx_c = LANE_W'(LANES - 1) - lane;
`else
    idx_c = lane;
`endif
  end

  always_comb begin
    pix_c = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (idx_c == LANE_W'(i)) begin
        pix_c = word[i*OUT_W +: OUT_W];
      end
    end
  end

endmodule

// File: rtl/ddr_rd_unpack_256to16.sv
// 256-bit DDR read word to 16-bit pixel unpacker with a 2-entry prefetch buffer.
// Build option: UNPACK_MSB_FIRST_EN reverses lane order (handled in unpack_lane_mux).
module ddr_rd_unpack_256to16
  import ddr_rd_unpack_256to16_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_vld,
  output logic             in_rdy,
  output logic [OUT_W-1:0] out_data,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [1:0]       lvl
);

  localparam int unsigned LANES  = IN_W / OUT_W;
  localparam int unsigned LANE_W = $clog2(LANES);

  occ_e              occ_q, occ_n;
  logic [LANE_W-1:0] lane_q, lane_n;
  logic [IN_W-1:0]   slot0_q, slot0_n;
  logic [IN_W-1:0]   slot1_q, slot1_n;
  logic              rdy_q, rdy_n;

  logic push_c;
  logic pix_pop_c;
  logic last_lane_c;
  logic word_pop_c;

  // Ready comes from a register so out_rdy never reaches in_rdy combinationally
  assign in_rdy  = rdy_q & ~flush;
  assign out_vld = (occ_q != OCC_EMPTY);
  assign lvl     = occ_q;

  assign push_c      = in_vld & in_rdy;
  assign pix_pop_c   = out_vld & out_rdy & ~flush;
  assign last_lane_c = (lane_q == LANE_W'(LANES - 1));
  assign word_pop_c  = pix_pop_c & last_lane_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q   <= OCC_EMPTY;
      lane_q  <= '0;
      slot0_q <= '0;
      slot1_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      occ_q   <= occ_n;
      lane_q  <= lane_n;
      slot0_q <= slot0_n;
      slot1_q <= slot1_n;
      rdy_q   <= rdy_n;
    end
  end

  // Occupancy FSM, slot movement and lane counter
  always_comb begin
    occ_n   = occ_q;
    lane_n  = lane_q;
    slot0_n = slot0_q;
    slot1_n = slot1_q;

    if (flush) begin
      occ_n  = OCC_EMPTY;
      lane_n = '0;
    end else begin
      if (pix_pop_c) begin
        lane_n = last_lane_c ? '0 : lane_q + LANE_W'(1);
      end

      case (occ_q)
        OCC_EMPTY: begin
          if (push_c) begin
            slot0_n = in_data;
            occ_n   = OCC_ONE;
          end
        end
        OCC_ONE: begin
          // Refill on the last-lane pop goes straight into slot0: no bubble
          if (push_c && word_pop_c) begin
            slot0_n = in_data;
          end else if (push_c) begin
            slot1_n = in_data;
            occ_n   = OCC_FULL;
          end else if (word_pop_c) begin
            occ_n = OCC_EMPTY;
          end
        end
        OCC_FULL: begin
          if (word_pop_c) begin
            slot0_n = slot1_q;
            occ_n   = OCC_ONE;
          end
        end
        default: begin
          occ_n = OCC_EMPTY;
        end
      endcase
    end

    rdy_n = (occ_n != OCC_FULL);
  end

  unpack_lane_mux #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .LANES (LANES),
    .LANE_W(LANE_W)
  ) u_lane_mux (
    .word (slot0_q),
    .lane (lane_q),
    .pix_c(out_data)
  );

endmodule

// File: tb/tb_ddr_rd_unpack_256to16.sv
// Scoreboard bench for ddr_rd_unpack_256to16: expected pixels are queued on each
// accepted word and a negedge monitor pops and compares on every output transfer.
module tb_ddr_rd_unpack_256to16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic [255:0] in_data;
  logic         in_vld;
  logic         in_rdy;
  logic [15:0]  out_data;
  logic         out_vld;
  logic         out_rdy;
  logic [1:0]   lvl;

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  ddr_rd_unpack_256to16 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .in_data (in_data),
    .in_vld  (in_vld),
    .in_rdy  (in_rdy),
    .out_data(out_data),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .lvl     (lvl)
  );

  // Word whose lane i (LSB-first position) holds base + i
  function automatic logic [255:0] mk_word(input logic [15:0] base);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[i*16 +: 16] = base + 16'(i);
    return w;
  endfunction

  // Pixel expected at output position i of word w
  function automatic logic [15:0] lane_px(input logic [255:0] w, input int i);
`ifdef UNPACK_MSB_FIRST_EN
    return w[(15-i)*16 +: 16];
`else
    return w[i*16 +: 16];
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_word(input logic [255:0] w);
    for (int i = 0; i < 16; i++) exp_q.push_back(lane_px(w, i));
  endtask

  // Offer one word; returns at posedge+1 after acceptance
  task automatic push_word(input logic [255:0] w);
    bit ok = 1'b0;
    in_data = w;
    in_vld  = 1'b1;
    for (int n = 0; n < 400 && !ok; n++) begin
      @(negedge clk);
      ok = in_rdy;
      @(posedge clk);
      #1;
    end
    in_vld = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_timeout: word %0h not accepted", w[15:0]);
    end
  endtask

  task automatic drain(input string name);
    for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  // Output monitor plus occupancy invariants
  always @(negedge clk) begin
    if (rst_n) begin
      chk("lvl_range", 32'(lvl == 2'd3), 32'd0);
      if (lvl == 2'd2) chk("in_rdy_when_full", 32'(in_rdy), 32'd0);
      if (out_vld && out_rdy && !flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pixel: got %0h expected none", out_data);
        end else begin
          chk("pixel", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] w0;
    int gaps;
    rst_n   = 1'b0;
    flush   = 1'b0;
    in_vld  = 1'b0;
    in_data = '0;
    out_rdy = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_rdy", 32'(in_rdy), 32'd0);
    chk("rst_out_vld", 32'(out_vld), 32'd0);
    chk("rst_lvl", 32'(lvl), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_rdy_same_cycle", 32'(in_rdy), 32'd0);
    @(posedge clk);
    #1;
    chk("release_in_rdy_next", 32'(in_rdy), 32'd1);

    // Single word, lane i = i
    out_rdy = 1'b1;
    push_word(mk_word(16'h0000));
    chk("single_latency_vld", 32'(out_vld), 32'd1);
    for (int i = 0; i < 16; i++) begin
`ifdef UNPACK_MSB_FIRST_EN
      exp_q.push_back(16'(15 - i));
`else
      exp_q.push_back(16'(i));
`endif
    end
    drain("single_drain");
    chk("single_vld_after", 32'(out_vld), 32'd0);
    chk("single_lvl_after", 32'(lvl), 32'd0);

    // Back-to-back: 4 words, 64 pixels without a gap
    fork
      begin
        for (int k = 0; k < 4; k++) begin
          w0 = mk_word(16'h1000 * 16'(k + 1));
          push_word(w0);
          expect_word(w0);
        end
      end
      begin
        gaps = 0;
        for (int n = 0; n < 50 && !out_vld; n++) begin
          @(posedge clk);
          #1;
        end
        for (int n = 0; n < 64; n++) begin
          if (!out_vld) gaps++;
          @(posedge clk);
          #1;
        end
        chk("b2b_gaps", 32'(gaps), 32'd0);
      end
    join
    drain("b2b_drain");

    // Backpressure with 3 words offered
    out_rdy = 1'b0;
    fork
      begin
        push_word(mk_word(16'h5000)); expect_word(mk_word(16'h5000));
        push_word(mk_word(16'h6000)); expect_word(mk_word(16'h6000));
        push_word(mk_word(16'h7000)); expect_word(mk_word(16'h7000));
      end
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("bp_lvl", 32'(lvl), 32'd2);
        chk("bp_in_rdy", 32'(in_rdy), 32'd0);
        chk("bp_out_vld", 32'(out_vld), 32'd1);
        chk("bp_frozen_data", 32'(out_data), 32'(lane_px(mk_word(16'h5000), 0)));
        out_rdy = 1'b1;
      end
    join
    drain("bp_drain");

    // Flush with lvl=2 after 5 pixels
    out_rdy = 1'b0;
    push_word(mk_word(16'h8000)); expect_word(mk_word(16'h8000));
    push_word(mk_word(16'h9000)); expect_word(mk_word(16'h9000));
    chk("pre_flush_lvl", 32'(lvl), 32'd2);
    out_rdy = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    flush   = 1'b1;
    in_vld  = 1'b1;
    in_data = mk_word(16'hA000);
    #1;
    chk("flush_in_rdy", 32'(in_rdy), 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    flush  = 1'b0;
    in_vld = 1'b0;
    chk("flush_lvl", 32'(lvl), 32'd0);
    chk("flush_out_vld", 32'(out_vld), 32'd0);
    push_word(mk_word(16'hB000)); expect_word(mk_word(16'hB000));
    chk("post_flush_lane0", 32'(out_data), 32'(lane_px(mk_word(16'hB000), 0)));
    drain("post_flush_drain");

    // Async reset mid-burst
    push_word(mk_word(16'hC000)); expect_word(mk_word(16'hC000));
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("midrst_out_vld", 32'(out_vld), 32'd0);
    chk("midrst_in_rdy", 32'(in_rdy), 32'd0);
    chk("midrst_lvl", 32'(lvl), 32'd0);
    chk("midrst_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push_word(mk_word(16'hD000)); expect_word(mk_word(16'hD000));
    chk("after_rst_lane0", 32'(out_data), 32'(lane_px(mk_word(16'hD000), 0)));
    drain("after_rst_drain");
    chk("final_out_vld", 32'(out_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
